// File: rtl/sq_wave_gen_if.sv
// sq_wave_gen_if -- control/status bundle for the square-wave generator.
//   en           : run request (level)
//   sw[3:0]      : period select, P = (sw+1)*DIV_BASE clocks
//   duty[3:0]    : high time in sixteenths of P (only with SQ_DUTY_EN)
//   SQ_WAVE      : square-wave bit
//   period_start : one-cycle pulse on the first cycle of each period
//   busy         : generator in RUN or STOP
// Modports: master = stimulus side, slave = generator side.
// Optional feature macro: SQ_DUTY_EN.
interface sq_wave_gen_if;
  logic       en;
  logic [3:0] sw;
`ifdef SQ_DUTY_EN
  logic [3:0] duty;
`endif
  logic       SQ_WAVE;
  logic       period_start;
  logic       busy;

`ifdef SQ_DUTY_EN
  modport master (output en, sw, duty, input SQ_WAVE, period_start, busy);
  modport slave  (input en, sw, duty, output SQ_WAVE, period_start, busy);
`else
  modport master (output en, sw, input SQ_WAVE, period_start, busy);
  modport slave  (input en, sw, output SQ_WAVE, period_start, busy);
`endif
endinterface

// File: rtl/sq_wave_gen.sv
// sq_wave_gen -- registered square-wave generator with IDLE/RUN/STOP FSM.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : sq_wave_gen_if.slave (en, sw, [duty], SQ_WAVE, period_start, busy)
// Parameter DIV_BASE (2..64): clocks per period unit.
// Macro SQ_DUTY_EN: adds the duty input; H = floor(duty*P/16), else H = floor(P/2).
module sq_wave_gen #(
  parameter int unsigned DIV_BASE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  sq_wave_gen_if.slave  bus
);

  localparam int unsigned CW = $clog2(16 * DIV_BASE);
  localparam int unsigned PW = 16;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sw_q, sw_d;
`ifdef SQ_DUTY_EN
  logic [3:0]    duty_q, duty_d;
`endif
  logic          wave_q, wave_d;
  logic          pstart_q, pstart_d;
  logic          busy_q, busy_d;

  logic [PW-1:0] p_cur, p_nxt, h_nxt;
  logic          last;
  logic          capture;
  logic          active_d;

  // Period of the running shadow value decides where the current period ends.
  assign p_cur = (PW'(sw_q) + PW'(1)) * PW'(DIV_BASE);
  assign last  = (PW'(cnt_q) == (p_cur - PW'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sw_q     <= '0;
`ifdef SQ_DUTY_EN
      duty_q   <= '0;
`endif
      wave_q   <= 1'b0;
      pstart_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_q     <= sw_d;
`ifdef SQ_DUTY_EN
      duty_q   <= duty_d;
`endif
      wave_q   <= wave_d;
      pstart_q <= pstart_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic. RUN and STOP share counting; en only picks which of
  // the two we stay in, and at the period end en=0 returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.en) begin
          state_d = RUN;
          capture = 1'b1;
        end
      end
      RUN, STOP: begin
        if (last) begin
          cnt_d   = '0;
          state_d = bus.en ? RUN : IDLE;
          capture = bus.en;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = bus.en ? RUN : STOP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    sw_d = capture ? bus.sw : sw_q;
`ifdef SQ_DUTY_EN
    duty_d = capture ? bus.duty : duty_q;
`endif
  end

  // Output logic: evaluated on the next state so the registered outputs
  // line up with state_q/cnt_q in the same cycle.
  always_comb begin
    p_nxt = (PW'(sw_d) + PW'(1)) * PW'(DIV_BASE);
`ifdef SQ_DUTY_EN
    h_nxt = (PW'(duty_d) * p_nxt) >> 4;
`else
    h_nxt = p_nxt >> 1;
`endif
    active_d = (state_d != IDLE);
    wave_d   = active_d && (PW'(cnt_d) < h_nxt);
    pstart_d = active_d && (cnt_d == '0);
    busy_d   = active_d;
  end

  assign bus.SQ_WAVE      = wave_q;
  assign bus.period_start = pstart_q;
  assign bus.busy         = busy_q;

endmodule
